// File: rtl/aim_pkg.sv
// Shared constants and types for the AIM match serializer slice.
// LANES is aligned with AIM's W_C_LENGTH; every file of the slice imports this package.
package aim_pkg;

   localparam int LANES  = 32;
   localparam int POS_W  = 9;
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = $clog2(LANES + 1);

   typedef struct packed {
      logic [LANE_W-1:0] lane;
      logic [POS_W-1:0]  pos;
      logic              last;
   } match_entry_t;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} ser_state_e;

   // Index of the lowest set bit; descending loop so the lowest index wins.
   function automatic logic [LANE_W-1:0] lowest_set(input logic [LANES-1:0] m);
      lowest_set = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i]) lowest_set = LANE_W'(i);
      end
   endfunction

endpackage

// File: rtl/aim_match_fifo.sv
// Synchronous FIFO of match entries with wrap-bit pointers.
// A pop frees the head slot in the same cycle, so push is accepted when full if popping.
module aim_match_fifo
   import aim_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  match_entry_t din,
   input  logic         pop,
   output match_entry_t dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   match_entry_t mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is not reset; readers gate dout with !empty, so stale data is never seen.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/aim_match_serializer.sv
// Captures AIM's match vector on i_finish and streams set lanes, lowest first, as {lane, pos}.
// Defining AIM_SERIALIZER_CNT_EN adds o_match_cnt (popcount of the captured vector).
module aim_match_serializer
   import aim_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_finish,
   input  logic [LANES-1:0]            i_valid,
   input  logic [LANES-1:0][POS_W-1:0] i_pos,
   output logic                        o_busy,
   output logic                        o_m_valid,
   input  logic                        i_m_ready,
   output logic [LANE_W-1:0]           o_m_lane,
   output logic [POS_W-1:0]            o_m_pos,
   output logic                        o_m_last,
   output logic                        o_done,
   output logic                        o_drop
`ifdef AIM_SERIALIZER_CNT_EN
   ,
   output logic [CNT_W-1:0]            o_match_cnt
`endif
);

   ser_state_e                  state;
   logic [LANES-1:0]            mask;
   logic [LANES-1:0]            mask_next;
   logic [LANES-1:0][POS_W-1:0] pos_q;
   logic [LANE_W-1:0]           lane_k;
   match_entry_t                push_entry;
   match_entry_t                head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        capture;

   assign mask_next  = mask & (mask - LANES'(1));
   assign lane_k     = lowest_set(mask);
   assign push_entry = '{lane: lane_k, pos: pos_q[lane_k], last: (mask_next == '0)};

   assign fifo_pop   = o_m_valid && i_m_ready;
   assign fifo_push  = (state == SCAN) && (mask != '0) && (!fifo_full || fifo_pop);
   // A finish coinciding with o_done is rejected as well, even though state is already IDLE.
   assign capture    = i_finish && (state == IDLE) && !o_done;

   assign o_busy     = (state != IDLE);
   assign o_m_valid  = !fifo_empty;
   assign o_m_lane   = o_m_valid ? head.lane : '0;
   assign o_m_pos    = o_m_valid ? head.pos  : '0;
   assign o_m_last   = o_m_valid && head.last;

   aim_match_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (fifo_push),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         mask   <= '0;
         o_done <= 1'b0;
         o_drop <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_finish && !capture) o_drop <= 1'b1;
         case (state)
            IDLE: begin
               if (capture) begin
                  mask  <= i_valid;
                  state <= (i_valid == '0) ? DRAIN : SCAN;
               end
            end
            SCAN: begin
               if (fifo_push) begin
                  mask <= mask_next;
                  if (mask_next == '0) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  o_done <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (capture) pos_q <= i_pos;
   end

`ifdef AIM_SERIALIZER_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        o_match_cnt <= '0;
      else if (capture) o_match_cnt <= CNT_W'($countones(i_valid));
   end
`endif

endmodule

// File: tb/tb_aim_match_serializer.sv
// Directed bench for aim_match_serializer; inputs driven and outputs sampled on the falling edge.
// Define AIM_SERIALIZER_CNT_EN to also check o_match_cnt.
module tb_aim_match_serializer;
   import aim_pkg::*;

   logic                        i_clk;
   logic                        i_rst;
   logic                        i_finish;
   logic [LANES-1:0]            i_valid;
   logic [LANES-1:0][POS_W-1:0] i_pos;
   logic                        o_busy;
   logic                        o_m_valid;
   logic                        i_m_ready;
   logic [LANE_W-1:0]           o_m_lane;
   logic [POS_W-1:0]            o_m_pos;
   logic                        o_m_last;
   logic                        o_done;
   logic                        o_drop;
`ifdef AIM_SERIALIZER_CNT_EN
   logic [CNT_W-1:0]            o_match_cnt;
`endif

   int checks = 0;
   int errors = 0;

   aim_match_serializer dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_finish  (i_finish),
      .i_valid   (i_valid),
      .i_pos     (i_pos),
      .o_busy    (o_busy),
      .o_m_valid (o_m_valid),
      .i_m_ready (i_m_ready),
      .o_m_lane  (o_m_lane),
      .o_m_pos   (o_m_pos),
      .o_m_last  (o_m_last),
      .o_done    (o_done),
`ifdef AIM_SERIALIZER_CNT_EN
      .o_match_cnt (o_match_cnt),
`endif
      .o_drop    (o_drop)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_entry(input string tag, input int lane, input int pos, input int last);
      check({tag, ".valid"}, 32'(o_m_valid), 1);
      check({tag, ".lane"},  32'(o_m_lane),  lane);
      check({tag, ".pos"},   32'(o_m_pos),   pos);
      check({tag, ".last"},  32'(o_m_last),  last);
   endtask

   // Returns on the falling edge where the capture edge has just passed.
   task automatic pulse_finish(input logic [LANES-1:0] v);
      i_valid  = v;
      i_finish = 1'b1;
      @(negedge i_clk);
      i_finish = 1'b0;
   endtask

   // Returns on the falling edge where o_done is seen, or after the budget expires.
   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge i_clk);
         if (o_done) seen = 1'b1;
      end
      check({tag, ".done_seen"}, 32'(seen), 1);
   endtask

   initial begin
      int idx;
      int lasts;
      bit have_held;
      logic [31:0] held;

      i_rst = 1'b1; i_finish = 1'b0; i_valid = '0; i_m_ready = 1'b1;
      for (int k = 0; k < LANES; k++) i_pos[k] = POS_W'(k + 4);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("rst.valid", 32'(o_m_valid), 0);
      check("rst.busy",  32'(o_busy),    0);
      check("rst.done",  32'(o_done),    0);
      check("rst.drop",  32'(o_drop),    0);
      check("rst.lane",  32'(o_m_lane),  0);
`ifdef AIM_SERIALIZER_CNT_EN
      check("rst.cnt",   32'(o_match_cnt), 0);
`endif

      // Three lanes, consumer always ready: one entry per cycle.
      pulse_finish(32'h0000_0411);
      check("t1.busy",  32'(o_busy),    1);
      check("t1.pre",   32'(o_m_valid), 0);
      @(negedge i_clk); expect_entry("t1.e0", 0, 4, 0);
      @(negedge i_clk); expect_entry("t1.e1", 4, 8, 0);
      @(negedge i_clk); expect_entry("t1.e2", 10, 14, 1);
      @(negedge i_clk);
      check("t1.empty", 32'(o_m_valid), 0);
      check("t1.nodone", 32'(o_done),   0);
      @(negedge i_clk);
      check("t1.done",  32'(o_done),    1);
      check("t1.idle",  32'(o_busy),    0);
      @(negedge i_clk);
      check("t1.pulse", 32'(o_done),    0);

      // Empty snapshot.
      pulse_finish('0);
      check("t2.busy",   32'(o_busy),    1);
      check("t2.valid",  32'(o_m_valid), 0);
      check("t2.nodone", 32'(o_done),    0);
      @(negedge i_clk);
      check("t2.done",   32'(o_done),    1);
      check("t2.idle",   32'(o_busy),    0);
      check("t2.valid1", 32'(o_m_valid), 0);
      @(negedge i_clk);
      check("t2.pulse",  32'(o_done),    0);

      // All lanes with a toggling consumer: order, stall stability, single last.
      i_m_ready = 1'b0;
      pulse_finish('1);
      idx = 0; lasts = 0; have_held = 1'b0; held = '0;
      for (int c = 0; c < 200 && idx < 32; c++) begin
         i_m_ready = ~i_m_ready;
         if (o_m_valid) begin
            if (have_held) check("t3.hold", {17'd0, o_m_lane, o_m_pos, o_m_last}, held);
            if (i_m_ready) begin
               check("t3.lane", 32'(o_m_lane), idx);
               check("t3.pos",  32'(o_m_pos),  idx + 4);
               check("t3.last", 32'(o_m_last), (idx == 31) ? 1 : 0);
               if (o_m_last) lasts++;
               idx++;
               have_held = 1'b0;
            end else begin
               held      = {17'd0, o_m_lane, o_m_pos, o_m_last};
               have_held = 1'b1;
            end
         end
         @(negedge i_clk);
      end
      check("t3.count", 32'(idx),   32);
      check("t3.lasts", 32'(lasts), 1);
      i_m_ready = 1'b1;
      wait_done("t3", 10);
      @(negedge i_clk);

      // Second finish while busy is dropped; the first snapshot is unaffected.
      pulse_finish(32'h0000_0411);
      @(negedge i_clk);
      expect_entry("t4.e0", 0, 4, 0);
      check("t4.nodrop", 32'(o_drop), 0);
      @(negedge i_clk);
      expect_entry("t4.e1", 4, 8, 0);
      i_valid  = 32'h0000_0002;
      i_finish = 1'b1;
      @(negedge i_clk);
      i_finish = 1'b0;
      expect_entry("t4.e2", 10, 14, 1);
      check("t4.drop", 32'(o_drop), 1);
      wait_done("t4", 10);
      // A finish in the o_done cycle is also rejected.
      i_finish = 1'b1;
      i_valid  = 32'h0000_0001;
      @(negedge i_clk);
      i_finish = 1'b0;
      check("t4.donecap", 32'(o_busy), 0);
      @(negedge i_clk);
      check("t4.novalid", 32'(o_m_valid), 0);
      check("t4.sticky",  32'(o_drop),    1);

      // Reset after two of five entries, then a fresh capture.
      pulse_finish(32'h0000_02AA);
      @(negedge i_clk); expect_entry("t5.e0", 1, 5, 0);
      @(negedge i_clk); expect_entry("t5.e1", 3, 7, 0);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("t5.valid", 32'(o_m_valid), 0);
      check("t5.busy",  32'(o_busy),    0);
      check("t5.drop",  32'(o_drop),    0);
      check("t5.lane",  32'(o_m_lane),  0);
      check("t5.pos",   32'(o_m_pos),   0);
      check("t5.last",  32'(o_m_last),  0);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         check("t5.nodone", 32'(o_done),    0);
         check("t5.idle",   32'(o_m_valid), 0);
      end
      pulse_finish(32'h0000_8001);
      check("t5.pre", 32'(o_m_valid), 0);
      @(negedge i_clk); expect_entry("t5.f0", 0, 4, 0);
      @(negedge i_clk); expect_entry("t5.f1", 15, 19, 1);
      wait_done("t5", 10);

`ifdef AIM_SERIALIZER_CNT_EN
      @(negedge i_clk);
      pulse_finish(32'h0000_00F0);
      check("cnt.val", 32'(o_match_cnt), 4);
      wait_done("cnt", 20);
      check("cnt.hold", 32'(o_match_cnt), 4);
`endif

      @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
